ecg_cnn_udiv_19ns_11ns_9_seq: RTL and testbench



---
 rtl/ecg_cnn_udiv_19ns_11ns_9_seq.sv | 126 ++++++++++++
 tb/tb_ecg_cnn_udiv_19ns_11ns_9_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_cnn_udiv_19ns_11ns_9_seq.sv
// Sequential restoring radix-2 unsigned divider, 19-bit / 11-bit -> saturated 9-bit quotient.
// Optional macro ECG_CNN_DIV_ROUND_EN selects round-to-nearest (ties up) instead of truncation.
module ecg_cnn_udiv_19ns_11ns_9_seq #(
  parameter int din0_WIDTH = 19,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 9
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

`ifdef ECG_CNN_DIV_ROUND_EN
  localparam int QW = din0_WIDTH + 1;
`else
  localparam int QW = din0_WIDTH;
`endif
  localparam int CW = $clog2(QW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [QW-1:0]         dvd;
  logic [din1_WIDTH-1:0] prem;
  logic [din1_WIDTH-1:0] dvs;
  logic                  dbz_r;

  logic [QW-1:0]                eff;
  logic [din1_WIDTH:0]          shifted;
  logic signed [din1_WIDTH+1:0] trial;
  logic                         ge;
  logic [din1_WIDTH-1:0]        prem_nxt;
  logic [QW-1:0]                dvd_nxt;

  // Quotient bits at or above dout_WIDTH force all ones; a zero divisor also yields all ones.
  function automatic logic [dout_WIDTH-1:0] sat_q(input logic [QW-1:0] q, input logic z);
    logic [dout_WIDTH-1:0] res;
    if (z || (|q[QW-1:dout_WIDTH]))
      res = '1;
    else
      res = q[dout_WIDTH-1:0];
    return res;
  endfunction

  function automatic logic ovf_q(input logic [QW-1:0] q, input logic z);
    return (|q[QW-1:dout_WIDTH]) && !z;
  endfunction

  // Half the divisor added up front turns truncation into round-half-up; din1==0 adds nothing.
  always_comb begin
    eff = QW'(din0);
`ifdef ECG_CNN_DIV_ROUND_EN
    eff = QW'(din0) + QW'(din1 >> 1);
`endif
  end

  // One restoring step: shift in the next dividend MSB, keep the difference if it did not go negative.
  always_comb begin
    shifted  = {prem, dvd[QW-1]};
    trial    = $signed({1'b0, shifted}) - $signed({2'b00, dvs});
    ge       = (trial >= 0);
    prem_nxt = ge ? trial[din1_WIDTH-1:0] : shifted[din1_WIDTH-1:0];
    dvd_nxt  = {dvd[QW-2:0], ge};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
      cnt   <= '0;
      dvd   <= '0;
      prem  <= '0;
      dvs   <= '0;
      dbz_r <= 1'b0;
      dout  <= '0;
      rem   <= '0;
      ovf   <= 1'b0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd   <= eff;
            dvs   <= din1;
            prem  <= '0;
            dbz_r <= (din1 == '0);
            cnt   <= CW'(QW);
            state <= BUSY;
          end
        end
        BUSY: begin
          dvd  <= dvd_nxt;
          prem <= prem_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            dout  <= sat_q(dvd_nxt, dbz_r);
            ovf   <= ovf_q(dvd_nxt, dbz_r);
            rem   <= prem_nxt;
            dbz   <= dbz_r;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_cnn_udiv_19ns_11ns_9_seq.sv
// Self-checking bench for ecg_cnn_udiv_19ns_11ns_9_seq against an arithmetic reference model.
module tb_ecg_cnn_udiv_19ns_11ns_9_seq;

`ifdef ECG_CNN_DIV_ROUND_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 19;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [18:0] din0;
  logic [10:0] din1;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  dout;
  logic [10:0] rem;
  logic        ovf;
  logic        dbz;

  int n_cmp = 0;
  int n_fail = 0;

  ecg_cnn_udiv_19ns_11ns_9_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .rem(rem), .ovf(ovf), .dbz(dbz)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference: plain integer division with optional half-divisor rounding and saturation.
  function automatic void model(input logic [18:0] a, input logic [10:0] b,
                                output logic [8:0] q, output logic [10:0] r,
                                output logic o, output logic z);
    longint e, full;
    e = longint'(a);
`ifdef ECG_CNN_DIV_ROUND_EN
    e = e + longint'(b / 2);
`endif
    if (b == 0) begin
      q = 9'h1FF; r = a[10:0]; o = 1'b0; z = 1'b1;
    end else begin
      full = e / longint'(b);
      r = 11'(e % longint'(b));
      o = (full > 511);
      q = o ? 9'h1FF : 9'(full);
      z = 1'b0;
    end
  endfunction

  // Drives one operation with out_ready high; lat=-2 on accept timeout, -1 on result timeout.
  task automatic do_op(input logic [18:0] a, input logic [10:0] b,
                       output logic [8:0] gd, output logic [10:0] gr,
                       output logic go, output logic gz, output int lat);
    int n;
    n = 0;
    out_ready = 1'b1;
    din0 = a; din1 = b; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(posedge ap_clk); #1; n++; end
    gd = '0; gr = '0; go = 1'b0; gz = 1'b0;
    if (!in_ready) begin
      in_valid = 1'b0; lat = -2;
      return;
    end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    din0 = 19'($urandom); din1 = 11'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge ap_clk); #1; lat++; end
    gd = dout; gr = rem; go = ovf; gz = dbz;
    if (!out_valid) lat = -1;
    else begin @(posedge ap_clk); #1; end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (dout !== 9'd0) begin n_fail++; $display("FAIL reset_dout: got %0d want 0", dout); end
    n_cmp++; if (rem !== 11'd0) begin n_fail++; $display("FAIL reset_rem: got %0d want 0", rem); end
    n_cmp++; if ({ovf, dbz} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {ovf, dbz}); end
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [18:0] a [6] = '{19'd1000, 19'd524287, 19'd511, 19'd100, 19'd0, 19'd2047};
    logic [10:0] b [6] = '{11'd7, 11'd1, 11'd1, 11'd0, 11'd5, 11'd2047};
    logic [8:0] gd, ed; logic [10:0] gr, er; logic go, gz, eo, ez; int lat;
    for (int i = 0; i < 6; i++) begin
      model(a[i], b[i], ed, er, eo, ez);
      do_op(a[i], b[i], gd, gr, go, gz, lat);
      n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
      n_cmp++; if (gd !== ed) begin n_fail++; $display("FAIL dir%0d_dout: got %0d want %0d", i, gd, ed); end
      n_cmp++; if (gr !== er) begin n_fail++; $display("FAIL dir%0d_rem: got %0d want %0d", i, gr, er); end
      n_cmp++; if ({go, gz} !== {eo, ez}) begin n_fail++; $display("FAIL dir%0d_ovf_dbz: got %b want %b", i, {go, gz}, {eo, ez}); end
    end
    // Known answers for 1000/7 independent of the model.
    do_op(19'd1000, 11'd7, gd, gr, go, gz, lat);
`ifdef ECG_CNN_DIV_ROUND_EN
    n_cmp++; if ({gd, gr} !== {9'd143, 11'd2}) begin n_fail++; $display("FAIL kat_1000_7: got %0d r %0d want 143 r 2", gd, gr); end
`else
    n_cmp++; if ({gd, gr} !== {9'd142, 11'd6}) begin n_fail++; $display("FAIL kat_1000_7: got %0d r %0d want 142 r 6", gd, gr); end
`endif
  endtask

  task automatic test_random();
    logic [18:0] a; logic [10:0] b;
    logic [8:0] gd, ed; logic [10:0] gr, er; logic go, gz, eo, ez; int lat; int sel;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      a = (sel < 3) ? 19'($urandom_range(0, 6000)) : 19'($urandom);
      if (sel == 0) b = 11'd0;
      else if (sel < 4) b = 11'($urandom_range(1, 15));
      else b = 11'($urandom);
      model(a, b, ed, er, eo, ez);
      do_op(a, b, gd, gr, go, gz, lat);
      n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL rnd_latency %0d/%0d: got %0d want %0d", a, b, lat, LAT); end
      n_cmp++; if ({gd, gr, go, gz} !== {ed, er, eo, ez})
        begin n_fail++; $display("FAIL rnd_result %0d/%0d: got q=%0d r=%0d o=%b z=%b want q=%0d r=%0d o=%b z=%b", a, b, gd, gr, go, gz, ed, er, eo, ez); end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] ed, d0; logic [10:0] er, r0; logic eo, ez; int n;
    model(19'd10, 11'd4, ed, er, eo, ez);
    out_ready = 1'b0; din0 = 19'd10; din1 = 11'd4; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge ap_clk); #1; n++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", out_valid); end
    d0 = dout; r0 = rem;
    n_cmp++; if ({d0, r0} !== {ed, er}) begin n_fail++; $display("FAIL bp_result: got %0d r %0d want %0d r %0d", d0, r0, ed, er); end
    for (int c = 0; c < 5; c++) begin
      @(posedge ap_clk); #1;
      n_cmp++; if ({out_valid, in_ready, dout, rem} !== {1'b1, 1'b0, d0, r0})
        begin n_fail++; $display("FAIL bp_hold%0d: got v=%b rdy=%b q=%0d r=%0d want v=1 rdy=0 q=%0d r=%0d", c, out_valid, in_ready, dout, rem, d0, r0); end
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_midop();
    logic [8:0] gd, ed; logic [10:0] gr, er; logic go, gz, eo, ez; int lat; logic seen;
    out_ready = 1'b1; din0 = 19'd1000; din1 = 11'd7; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    n_cmp++; if ({in_ready, out_valid, dout, rem, ovf, dbz} !== {1'b1, 1'b0, 9'd0, 11'd0, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL midrst_values: got rdy=%b v=%b q=%0d r=%0d o=%b z=%b want reset values", in_ready, out_valid, dout, rem, ovf, dbz); end
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin @(posedge ap_clk); #1; seen |= out_valid; end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_valid: got %b want 0", seen); end
    model(19'd50, 11'd5, ed, er, eo, ez);
    do_op(19'd50, 11'd5, gd, gr, go, gz, lat);
    n_cmp++; if ({gd, gr} !== {ed, er} || gd !== 9'd10) begin n_fail++; $display("FAIL midrst_next: got %0d r %0d want %0d r %0d", gd, gr, ed, er); end
    n_cmp++; if (lat != LAT) begin n_fail++; $display("FAIL midrst_latency: got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    logic [18:0] a [3]; logic [10:0] b [3];
    logic [8:0] qd [$]; logic [10:0] qr [$]; int acc [$];
    logic [8:0] ed; logic [10:0] er; logic eo, ez;
    int idx, cyc; logic accepting, both;
    for (int i = 0; i < 3; i++) begin a[i] = 19'($urandom); b[i] = 11'($urandom_range(1, 2047)); end
    a[1] = 19'd1000; b[1] = 11'd7;
    out_ready = 1'b1; idx = 0; cyc = 0; both = 1'b0;
    din0 = a[0]; din1 = b[0]; in_valid = 1'b1;
    while (qd.size() < 3 && cyc < 300) begin
      accepting = in_valid && in_ready;
      both |= in_ready && out_valid;
      @(posedge ap_clk); #1; cyc++;
      if (accepting) begin
        acc.push_back(cyc); idx++;
        if (idx < 3) begin din0 = a[idx]; din1 = b[idx]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin qd.push_back(dout); qr.push_back(rem); end
    end
    in_valid = 1'b0;
    @(posedge ap_clk); #1;
    n_cmp++; if (qd.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", qd.size()); end
    n_cmp++; if (both !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done: got %b want 0", both); end
    for (int i = 0; i < 3 && i < qd.size(); i++) begin
      model(a[i], b[i], ed, er, eo, ez);
      n_cmp++; if ({qd[i], qr[i]} !== {ed, er}) begin n_fail++; $display("FAIL b2b_res%0d: got %0d r %0d want %0d r %0d", i, qd[i], qr[i], ed, er); end
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_cmp++; if (acc[i] - acc[i-1] != LAT + 2) begin n_fail++; $display("FAIL b2b_interval%0d: got %0d want %0d", i, acc[i] - acc[i-1], LAT + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
